icmp_echo_responder: RTL and testbench

ICMP_ECHO_RESPONDER -- requirements
Module: icmp_echo_responder

---
 rtl/icmp_echo_responder.sv | 127 ++++++++++++
 tb/tb_icmp_echo_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/icmp_echo_responder.sv
// icmp_echo_responder: buffers an ICMP echo request and streams back the echo reply
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_icmp_data/len/last/valid : request byte stream from IP receive
//   i_recv_src_ip/valid        : sender address, latched as reply destination
//   o_send_data/type/len/last/valid : reply byte stream toward IP transmit
//   o_dst_ip/o_dst_ip_valid    : reply destination, pulsed once per accepted request
module icmp_echo_responder #(
    parameter int          P_BUF_DEPTH = 1024,
    parameter logic [7:0]  P_SEND_TYPE = 8'd1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_icmp_data,
    input  logic [15:0] i_icmp_len,
    input  logic        i_icmp_last,
    input  logic        i_icmp_valid,
    input  logic [31:0] i_recv_src_ip,
    input  logic        i_recv_src_valid,
    output logic [7:0]  o_send_data,
    output logic [7:0]  o_send_type,
    output logic [15:0] o_send_len,
    output logic        o_send_last,
    output logic        o_send_valid,
    output logic [31:0] o_dst_ip,
    output logic        o_dst_ip_valid
);
    localparam int AW = $clog2(P_BUF_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [2:0] {IDLE, RECV, CHECK, SEND, DROP} state_t;
    state_t        state;
    logic [7:0]    mem [P_BUF_DEPTH];
    logic [CW-1:0] count, idx;
    logic [15:0]   len, csum, new_csum;
    logic [16:0]   sum;
    logic [7:0]    typ, code, rd_byte;
    logic [31:0]   src_ip;
    logic [AW-1:0] wa;
    logic          pend, pend_n, accept, full, wr_en;
    always_comb begin
        sum      = {1'b0, csum} + 17'h00800;
        new_csum = sum[15:0] + {15'b0, sum[16]};
        accept   = typ == 8'h08 && code == 8'h00 && 32'(count) == 32'(len) && 32'(count) >= 32'd8;
        full     = 32'(count) == 32'(P_BUF_DEPTH);
        wa       = state == IDLE ? '0 : count[AW-1:0];
        wr_en    = i_icmp_valid && (state == IDLE || (state == RECV && !full));
        // a stray packet overlapping CHECK/SEND must be swallowed unless it already ended
        pend_n   = i_icmp_valid ? !i_icmp_last : pend;
        rd_byte  = idx < CW'(2) ? 8'h00 : idx == CW'(2) ? new_csum[15:8] :
                   idx == CW'(3) ? new_csum[7:0] : mem[idx[AW-1:0]];
    end
    always_ff @(posedge i_clk)
        if (wr_en) mem[wa] <= i_icmp_data;
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state          <= IDLE;
            count          <= '0;
            idx            <= '0;
            len            <= '0;
            csum           <= '0;
            typ            <= '0;
            code           <= '0;
            src_ip         <= '0;
            pend           <= 1'b0;
            o_send_data    <= '0;
            o_send_type    <= '0;
            o_send_len     <= '0;
            o_send_last    <= 1'b0;
            o_send_valid   <= 1'b0;
            o_dst_ip       <= '0;
            o_dst_ip_valid <= 1'b0;
        end else begin
            o_dst_ip_valid <= 1'b0;
            if (i_recv_src_valid) src_ip <= i_recv_src_ip;
            if (wr_en && wa == AW'(0)) typ <= i_icmp_data;
            if (wr_en && wa == AW'(1)) code <= i_icmp_data;
            if (wr_en && wa == AW'(2)) csum[15:8] <= i_icmp_data;
            if (wr_en && wa == AW'(3)) csum[7:0] <= i_icmp_data;
            case (state)
                IDLE: if (i_icmp_valid) begin
                    len   <= i_icmp_len;
                    count <= CW'(1);
                    pend  <= 1'b0;
                    state <= i_icmp_last ? CHECK : RECV;
                end
                RECV: if (i_icmp_valid) begin
                    if (full) state <= i_icmp_last ? IDLE : DROP;
                    else begin
                        count <= count + 1'b1;
                        if (i_icmp_last) state <= CHECK;
                    end
                end
                CHECK: begin
                    pend <= pend_n;
                    if (accept) begin
                        o_dst_ip_valid <= 1'b1;
                        o_dst_ip       <= src_ip;
                        o_send_valid   <= 1'b1;
                        o_send_data    <= 8'h00;
                        o_send_len     <= len;
                        o_send_type    <= P_SEND_TYPE;
                        o_send_last    <= 1'b0;
                        idx            <= CW'(1);
                        state          <= SEND;
                    end else state <= pend_n ? DROP : IDLE;
                end
                SEND: begin
                    pend <= pend_n;
                    if (idx == count) begin
                        o_send_valid <= 1'b0;
                        o_send_last  <= 1'b0;
                        o_send_data  <= '0;
                        o_send_len   <= '0;
                        o_send_type  <= '0;
                        state        <= pend_n ? DROP : IDLE;
                    end else begin
                        o_send_data <= rd_byte;
                        o_send_last <= idx == count - 1'b1;
                        idx         <= idx + 1'b1;
                    end
                end
                DROP: if (i_icmp_valid && i_icmp_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icmp_echo_responder.sv
// tb_icmp_echo_responder: scoreboard bench for icmp_echo_responder
module tb_icmp_echo_responder;
    localparam int DEPTH = 64;
    typedef logic [7:0] bq_t [$];
    typedef struct {logic [7:0] d; logic last; logic [15:0] len; bit first;} rb_t;
    logic        clk = 0, rst = 0;
    logic [7:0]  i_icmp_data = 0;
    logic [15:0] i_icmp_len = 0;
    logic        i_icmp_last = 0, i_icmp_valid = 0, i_recv_src_valid = 0;
    logic [31:0] i_recv_src_ip = 0;
    logic [7:0]  o_send_data, o_send_type;
    logic [15:0] o_send_len;
    logic        o_send_last, o_send_valid, o_dst_ip_valid;
    logic [31:0] o_dst_ip;
    int cyc = 0, n_chk = 0, n_fail = 0;
    rb_t exp_q[$];
    logic [31:0] ip_q[$];
    int start_q[$];
    rb_t e;
    int s;
    icmp_echo_responder #(.P_BUF_DEPTH(DEPTH), .P_SEND_TYPE(8'd1)) dut (
        .i_clk(clk), .i_rst(rst), .i_icmp_data(i_icmp_data), .i_icmp_len(i_icmp_len),
        .i_icmp_last(i_icmp_last), .i_icmp_valid(i_icmp_valid), .i_recv_src_ip(i_recv_src_ip),
        .i_recv_src_valid(i_recv_src_valid), .o_send_data(o_send_data), .o_send_type(o_send_type),
        .o_send_len(o_send_len), .o_send_last(o_send_last), .o_send_valid(o_send_valid),
        .o_dst_ip(o_dst_ip), .o_dst_ip_valid(o_dst_ip_valid));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void chk(string nm, logic [31:0] a, logic [31:0] x);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, a, x, cyc);
        end
    endfunction
    always @(negedge clk) begin
        if (o_send_valid) begin
            if (exp_q.size() == 0) chk("unexpected_send_valid", 32'(o_send_valid), 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("send_data", 32'(o_send_data), 32'(e.d));
                chk("send_last", 32'(o_send_last), 32'(e.last));
                chk("send_len", 32'(o_send_len), 32'(e.len));
                chk("send_type", 32'(o_send_type), 32'd1);
                if (e.first) begin
                    s = start_q.pop_front();
                    chk("first_valid_cycle", 32'(cyc), 32'(s));
                end
            end
        end else if (rst) begin
            chk("idle_len_zero", 32'(o_send_len), 32'd0);
            chk("idle_type_last_zero", {o_send_type, 7'd0, o_send_last}, 32'd0);
        end
        if (o_dst_ip_valid) begin
            if (ip_q.size() == 0) chk("unexpected_dst_ip_valid", 32'(o_dst_ip_valid), 32'd0);
            else chk("dst_ip", o_dst_ip, ip_q.pop_front());
        end
    end
    function automatic bq_t mk(int n, logic [7:0] t, logic [7:0] c, logic [15:0] cs);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        if (n > 0) q[0] = t;
        if (n > 1) q[1] = c;
        if (n > 2) q[2] = cs[15:8];
        if (n > 3) q[3] = cs[7:0];
        return q;
    endfunction
    // Drives a packet and leaves its last byte on the bus; queues the reply if it should be echoed.
    task automatic send_pkt(input bq_t p, input logic [15:0] len, input logic [31:0] ip,
                            input bit gaps, input bit may_ok, output int lk);
        logic [16:0] sm;
        bq_t r;
        bit ok;
        ok = may_ok && p.size() >= 8 && p.size() <= DEPTH && p[0] == 8'h08 && p[1] == 8'h00 && int'(len) == p.size();
        foreach (p[i]) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                i_icmp_valid = 0; i_recv_src_valid = 0; i_icmp_last = 0;
            end
            @(posedge clk); #1;
            i_icmp_valid = 1; i_icmp_data = p[i]; i_icmp_len = len;
            i_icmp_last = (i == p.size() - 1); i_recv_src_valid = (i == 0); i_recv_src_ip = ip;
        end
        lk = cyc;
        if (ok) begin
            sm = {1'b0, p[2], p[3]} + 17'h0800;
            sm = {1'b0, sm[15:0]} + 17'(sm[16]);
            r = p; r[0] = 8'h00; r[1] = 8'h00; r[2] = sm[15:8]; r[3] = sm[7:0];
            foreach (r[i]) exp_q.push_back('{d: r[i], last: (i == r.size() - 1), len: len, first: (i == 0)});
            ip_q.push_back(ip);
            start_q.push_back(lk + 2);
        end
    endtask
    task automatic idle_in();
        @(posedge clk); #1;
        i_icmp_valid = 0; i_icmp_last = 0; i_recv_src_valid = 0;
    endtask
    task automatic drain(input string nm);
        int t = 0;
        while ((exp_q.size() != 0 || ip_q.size() != 0) && t < 500) begin @(posedge clk); t++; end
        repeat (4) @(posedge clk);
        #1;
        chk(nm, 32'(exp_q.size() + ip_q.size()), 32'd0);
    endtask
    initial begin
        bq_t v;
        int lk;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {o_send_data, o_send_type, 14'd0, o_send_last, o_send_valid}, 32'd0);
        chk("reset_len_ip", {o_send_len, 15'd0, o_dst_ip_valid}, 32'd0);
        chk("reset_dst_ip", o_dst_ip, 32'd0);
        rst = 1;
        repeat (2) @(posedge clk);
        v = '{8'h08, 8'h00, 8'hF7, 8'hFE, 8'h00, 8'h01, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_pkt(v, 16'd12, 32'hC0A80100, 0, 1, lk); idle_in(); drain("echo_basic");
        send_pkt(mk(10, 8'h08, 8'h00, 16'hF800), 16'd10, 32'h0A000001, 0, 1, lk); idle_in(); drain("csum_wrap");
        v[0] = 8'h00; send_pkt(v, 16'd12, 32'h01020304, 0, 1, lk); idle_in(); drain("type0_reject");
        v[0] = 8'h08; v[1] = 8'h01; send_pkt(v, 16'd12, 32'h01020304, 0, 1, lk); idle_in(); drain("code1_reject");
        v[1] = 8'h00; send_pkt(v, 16'd20, 32'h01020304, 0, 1, lk); idle_in(); drain("len_mismatch");
        send_pkt(mk(1, 8'h08, 8'h00, 16'h0), 16'd1, 32'h05050505, 0, 1, lk); idle_in(); drain("one_byte");
        send_pkt(mk(DEPTH + 1, 8'h08, 8'h00, 16'h1234), 16'(DEPTH + 1), 32'h06060606, 0, 1, lk); idle_in();
        send_pkt(mk(8, 8'h08, 8'h00, 16'h4321), 16'd8, 32'h07070707, 0, 1, lk); idle_in(); drain("oversize_then_ok");
        send_pkt(mk(DEPTH, 8'h08, 8'h00, 16'hABCD), 16'(DEPTH), 32'h08080808, 0, 1, lk); idle_in(); drain("full_depth");
        foreach (v[i]) if (i > 3) v[i] = 8'($urandom);
        for (int b = 0; b < 2; b++) begin
            send_pkt(v, 16'd12, 32'hC0A80102, 0, 1, lk);
            send_pkt(mk(b == 0 ? 20 : 5, 8'h08, 8'h00, 16'h1111), b == 0 ? 16'd20 : 16'd5, 32'hDEAD0000, 0, 0, lk);
            idle_in(); drain("back_to_back_first");
            send_pkt(mk(9, 8'h08, 8'h00, 16'h2222), 16'd9, 32'hC0A80103, 0, 1, lk); idle_in(); drain("after_b2b");
        end
        send_pkt(v, 16'd12, 32'hC0A80104, 0, 1, lk); idle_in();
        while (cyc < lk + 6) begin @(posedge clk); #1; end
        rst = 0;
        @(posedge clk); #1;
        exp_q.delete(); ip_q.delete(); start_q.delete();
        chk("midsend_reset_outputs", {o_send_data, o_send_type, 14'd0, o_send_last, o_send_valid}, 32'd0);
        chk("midsend_reset_len", {o_send_len, 15'd0, o_dst_ip_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1; rst = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_send_after_reset", 32'(o_send_valid), 32'd0);
        send_pkt(mk(16, 8'h08, 8'h00, 16'h0102), 16'd16, 32'hC0A80105, 0, 1, lk); idle_in(); drain("after_reset_echo");
        for (int k = 0; k < 30; k++) begin
            int n, sel;
            logic [15:0] l;
            n = $urandom_range(3, 40);
            sel = $urandom_range(0, 9);
            l = (sel == 2) ? 16'(n + 1) : 16'(n);
            send_pkt(mk(n, sel == 0 ? 8'h00 : 8'h08, sel == 1 ? 8'h03 : 8'h00, 16'($urandom)),
                     l, $urandom, 1, 1, lk);
            idle_in(); drain("random_pkt");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
